seconds_units_counter: RTL
==========================

SECONDS_UNITS_COUNTER -- requirements
Module: seconds_units_counter

Interface
REQ-001 SHALL have parameter DIV, default 100, meaning clk cycles per one-second tick (legal range 1..2^24).
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port enable  input  1  run control; 1 = prescaler and digit advance, 0 = hold.
REQ-005 SHALL have port m  input  1  count direction; 0 = up, 1 = down.
REQ-006 SHALL have port clr  input  1  synchronous clear of digit and prescaler.
REQ-007 SHALL have port load  input  1  synchronous load strobe (effective only per Configuration).
REQ-008 SHALL have port load_val  input  4  BCD value to load.
REQ-009 SHALL have port o  output  4  current units-of-seconds BCD digit, 0..9.
REQ-010 SHALL have port tick  output  1  combinational one-second strobe from the prescaler.
REQ-011 SHALL have port carry  output  1  combinational enable for the downstream tens-of-seconds stage.

Function
REQ-012 Prescaler SHALL count 0..DIV-1 on cycles with enable=1, wrapping DIV-1 -> 0; it SHALL hold its value while enable=0.
REQ-013 tick SHALL be 1 exactly when enable=1 and prescaler == DIV-1; with DIV=1, tick = enable.
REQ-014 On a cycle with tick=1, o SHALL update on that edge: up mode 0->1->...->9->0; down mode 9->8->...->0->9.
REQ-015 carry SHALL be tick & (m==0 ? o==9 : o==0), so the tens stage advances on the same edge on which o wraps.
REQ-016 carry SHALL be 0 whenever enable=0, clr=1, or (load=1 with LOAD effective).
REQ-017 Changing m mid-count SHALL take effect on the next tick; o and the prescaler SHALL be unaffected by the change itself.
REQ-018 Priority on a clock edge SHALL be: clr > load > tick-driven count > hold.
REQ-019 clr=1 SHALL set o=0 and prescaler=0 on the next edge, regardless of enable.
REQ-020 An effective load SHALL set o=load_val (values 10..15 clamp to 9) and prescaler=0 on the next edge, regardless of enable.
REQ-021 o SHALL never hold a value outside 0..9.
REQ-022 Prescaler width SHALL be the minimum that holds DIV-1 (at least 1 bit).

Reset
REQ-023 While reset=0, o SHALL be 0 and prescaler SHALL be 0, asynchronously and independent of clk.
REQ-024 While reset=0, tick and carry SHALL be 0.
REQ-025 After reset deasserts, the first tick SHALL occur on the DIV-th enabled cycle.
REQ-026 Reset asserted mid-count SHALL abandon the partial prescaler count, with no carry emitted.

Configuration
REQ-027 Macro SECONDS_UNITS_LOAD_EN SHALL control the load feature.
REQ-028 With SECONDS_UNITS_LOAD_EN defined, load/load_val SHALL behave per REQ-018 and REQ-020.
REQ-029 Without SECONDS_UNITS_LOAD_EN, the ports SHALL remain present, load and load_val SHALL be ignored, and priority SHALL be clr > count > hold.

Verification
REQ-030 DIV=4, m=0, enable=1 from reset, 40 cycles -> tick every 4th cycle; o steps 0..9; carry high once, in the cycle with o=9 and tick=1; o=0 after cycle 40.
REQ-031 DIV=4, m=1 from reset -> first tick: o 0->9 with carry=1 in that cycle; subsequent ticks give 8,7,...
REQ-032 DIV=4, enable dropped for 10 cycles with prescaler=2 -> o and prescaler frozen, tick and carry stay 0; tick occurs on the 2nd cycle after re-enable.
REQ-033 clr=1 and load=1 in the same cycle as tick with o=9 (up) -> o=0, prescaler=0, carry=0.
REQ-034 SECONDS_UNITS_LOAD_EN defined, load_val=12 -> o=9; load_val=5 -> o=5 and next tick after DIV cycles; macro undefined -> load has no effect on o.
REQ-035 reset pulsed low between clock edges with o=7 -> o=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/seconds_units_counter.sv
// Units-of-seconds BCD digit with a DIV-cycle prescaler, up/down count and carry to the tens stage.
// Optional synchronous load is built only when SECONDS_UNITS_LOAD_EN is defined.
module seconds_units_counter #(
   parameter int unsigned DIV = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       m,
   input  logic       clr,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] o,
   output logic       tick,
   output logic       carry
);

   localparam int unsigned    PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]  PRESC_TC = PW'(DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    digit_q, digit_d;
   logic [3:0]    load_clamped;
   logic          load_eff;
   logic          digit_wrap;

`ifdef SECONDS_UNITS_LOAD_EN
   assign load_eff = load;
`else
   logic unused_load;
   assign load_eff    = 1'b0;
   assign unused_load = ^{load, load_val};
`endif

   assign load_clamped = (load_val > 4'd9) ? 4'd9 : load_val;

   // reset is folded in so tick/carry stay low while the flops are held in reset
   assign tick       = reset & enable & (presc_q == PRESC_TC);
   assign digit_wrap = m ? (digit_q == 4'd0) : (digit_q == 4'd9);
   assign carry      = tick & digit_wrap & ~clr & ~load_eff;
   assign o          = digit_q;

   always_comb begin
      presc_d = presc_q;
      digit_d = digit_q;
      if (clr) begin
         presc_d = '0;
         digit_d = 4'd0;
      end else if (load_eff) begin
         presc_d = '0;
         digit_d = load_clamped;
      end else if (enable) begin
         presc_d = (presc_q == PRESC_TC) ? '0 : presc_q + PW'(1);
         if (tick) begin
            if (m)
               digit_d = (digit_q == 4'd0 || digit_q > 4'd9) ? 4'd9 : digit_q - 4'd1;
            else
               digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
         digit_q <= 4'd0;
      end else begin
         presc_q <= presc_d;
         digit_q <= digit_d;
      end
   end

endmodule
